// File: rtl/seq_divider.sv
// Multi-cycle unsigned restoring divider: one quotient bit per cycle, MSB first.
// Result and done arrive WIDTH cycles after the accepting edge; start is ignored while busy (no queuing).
module seq_divider #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             n_reset,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    // Dividend bits leave at the top while quotient bits enter at the bottom.
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             dbz_q, dbz_d;
    logic [WIDTH-1:0] quot_q, quot_d;
    logic [WIDTH-1:0] remo_q, remo_d;

    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   trial;
    logic             qbit;
    logic [WIDTH-1:0] acc_next;
    logic [WIDTH-1:0] rem_next;
    logic             accept;

    always_comb begin
        shifted  = {rem_q, acc_q[WIDTH-1]};
        trial    = shifted - {1'b0, dvs_q};
        qbit     = ~trial[WIDTH];
        rem_next = qbit ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
        acc_next = {acc_q[WIDTH-2:0], qbit};
        accept   = start & ~busy_q;

        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        dvs_d   = dvs_q;
        rem_d   = rem_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        dbz_d   = dbz_q;
        quot_d  = quot_q;
        remo_d  = remo_q;

        case (state_q)
            RUN: begin
                acc_d = acc_next;
                rem_d = rem_next;
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == '0) begin
                    // A zero divisor always succeeds the trial, so the loop itself
                    // yields an all-ones quotient and remainder equal to the dividend.
                    state_d = DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    quot_d  = acc_next;
                    remo_d  = rem_next;
                    dbz_d   = (dvs_q == '0);
                end
            end
            default: begin
                if (accept) begin
                    state_d = RUN;
                    busy_d  = 1'b1;
                    acc_d   = dividend;
                    dvs_d   = divisor;
                    rem_d   = '0;
                    cnt_d   = CNT_INIT;
                end else begin
                    state_d = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            dvs_q   <= '0;
            rem_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dbz_q   <= 1'b0;
            quot_q  <= '0;
            remo_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            dvs_q   <= dvs_d;
            rem_q   <= rem_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            dbz_q   <= dbz_d;
            quot_q  <= quot_d;
            remo_q  <= remo_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign quotient    = quot_q;
    assign remainder   = remo_q;
    assign div_by_zero = dbz_q;

endmodule
